// File: rtl/instr_fetch_queue.sv
// Instruction queue between I-cache fetch and decode: DEPTH-entry FIFO of {instr, pc} with flush.
// Optional macro IFQ_BYPASS_EN adds a combinational empty-queue bypass from in_* to out_*.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = `WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_instr,
  input  logic [W-1:0]     in_pc,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_instr,
  output logic [W-1:0]     out_pc,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic full, empty, clear, bypass, push, pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign clear = rst | flush;

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & in_valid & ~clear;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never touches storage.
  assign push = in_valid & ~full & ~clear & ~(bypass & out_ready);
  assign pop  = ~empty & out_ready & ~clear;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: in_instr, pc: in_pc};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: every output path assigns both fields in all branches, so no latch is inferred.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc    = in_pc;
    end else if (!empty) begin
      out_instr = mem_q[rd_ptr_q].instr;
      out_pc    = mem_q[rd_ptr_q].pc;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty | bypass;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-based reference model compared every cycle,
// plus directed literal expectations. Honours IFQ_BYPASS_EN the same way the design does.
`timescale 1ns/1ps

module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  word_t model_q [$];

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .PTR_W(2), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics applied at every rising edge.
  always @(posedge clk) begin
    bit do_byp, do_push, do_pop;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      do_byp  = BYP && (model_q.size() == 0) && in_valid;
      do_pop  = (model_q.size() != 0) && out_ready;
      do_push = in_valid && (model_q.size() != DEPTH) && !(do_byp && out_ready);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  // Compare process: outputs checked mid-cycle against the model every cycle after the first edge.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
    if (chk_en) begin
      e_valid = 1'b0;
      e_instr = '0;
      e_pc    = '0;
      if (model_q.size() != 0) begin
        e_valid = 1'b1;
        e_instr = model_q[0].instr;
        e_pc    = model_q[0].pc;
      end else if (BYP && in_valid && !flush && !rst) begin
        e_valid = 1'b1;
        e_instr = in_instr;
        e_pc    = in_pc;
      end
      check("mdl_count",     32'(count),     32'(model_q.size()));
      check("mdl_in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
      check("mdl_out_valid", 32'(out_valid), 32'(e_valid));
      check("mdl_out_instr", out_instr,      e_instr);
      check("mdl_out_pc",    out_pc,         e_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    tick();
    rst = 1'b0;

    // Reset state
    mid();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_count",     32'(count),     32'd0);

    // Two pushes, stalled decode, then drain in order
    tick();
    drive(1'b1, 32'h1111_1111, 32'h100); tick();
    drive(1'b1, 32'h2222_2222, 32'h104); tick();
    drive(1'b0, '0, '0);
    mid();
    check("two_count", 32'(count), 32'd2);
    check("two_instr", out_instr,  32'h1111_1111);
    check("two_pc",    out_pc,     32'h100);
    out_ready = 1'b1;
    tick();
    mid();
    check("pop1_instr", out_instr, 32'h2222_2222);
    check("pop1_pc",    out_pc,    32'h104);
    tick();
    mid();
    check("pop2_count", 32'(count), 32'd0);
    out_ready = 1'b0;
    tick();

    // Fill to full; fifth word waits until a pop frees a slot
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_00B0 + 32'(i), 32'h200 + 32'(4 * i));
      tick();
    end
    mid();
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head",     out_instr,     32'h0000_00B0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    mid();
    check("afterpop_count", 32'(count),    32'd3);
    check("afterpop_ready", 32'(in_ready), 32'd1);
    check("afterpop_head",  out_instr,     32'h0000_00B1);
    tick();
    drive(1'b0, '0, '0);
    mid();
    check("refill_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    repeat (4) tick();
    mid();
    check("drain_count", 32'(count), 32'd0);

    // Streaming push and pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_00A0 + 32'(i), 32'h300 + 32'(4 * i));
      tick();
    end
    drive(1'b0, '0, '0);
    mid();
`ifdef IFQ_BYPASS_EN
    check("stream_tail_count", 32'(count), 32'd0);
`else
    check("stream_tail_count", 32'(count), 32'd1);
    check("stream_tail_instr", out_instr,  32'h0000_00A9);
`endif
    tick();
    mid();
    check("stream_end_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Flush with a simultaneous push while holding 3 entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_00C0 + 32'(i), 32'h400 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h0000_00C3, 32'h40C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    mid();
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_instr", out_instr,      32'd0);
    drive(1'b1, 32'h0000_00D0, 32'h500);
    tick();
    drive(1'b0, '0, '0);
    mid();
    check("postflush_count", 32'(count), 32'd1);
    check("postflush_instr", out_instr,  32'h0000_00D0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while full and stalled, then a normal push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_00E0 + 32'(i), 32'h600 + 32'(4 * i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0000_00EE, 32'h6F0);
    tick();
    drive(1'b0, '0, '0);
    mid();
    check("rstfull_count", 32'(count), 32'd1);
    check("rstfull_instr", out_instr,  32'h0000_00EE);
    out_ready = 1'b1;
    tick();

    // Flush suppresses any same-cycle bypass on an empty queue
    drive(1'b1, 32'h1234_5678, 32'h700);
    flush = 1'b1;
    mid();
    check("flushbyp_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0;

    // Empty queue, word presented with decode ready
    drive(1'b1, 32'hDEAD_BEEF, 32'h800);
    mid();
`ifdef IFQ_BYPASS_EN
    check("byp_same_valid", 32'(out_valid), 32'd1);
    check("byp_same_instr", out_instr,      32'hDEAD_BEEF);
`else
    check("byp_same_valid", 32'(out_valid), 32'd0);
    check("byp_same_instr", out_instr,      32'd0);
`endif
    tick();
    drive(1'b0, '0, '0);
    mid();
`ifdef IFQ_BYPASS_EN
    check("byp_next_count", 32'(count), 32'd0);
`else
    check("byp_next_count", 32'(count), 32'd1);
    check("byp_next_instr", out_instr,  32'hDEAD_BEEF);
    check("byp_next_pc",    out_pc,     32'h800);
`endif
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
